// File: rtl/shift_pkg.sv
// shift_pkg: encodings shared by the shift controller and its stage datapath.
//   opcode_e  : SLL / SRL / SRA / ROR (ROR only implemented with SHIFT_ROTATE_EN)
//   state_e   : controller FSM states IDLE / SHIFT / DONE
//   STAGEn_AMT: fixed amount applied by stage index n (16, 8, 4, 2, 1)
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic [4:0] STAGE0_AMT = 5'd16;
  localparam logic [4:0] STAGE1_AMT = 5'd8;
  localparam logic [4:0] STAGE2_AMT = 5'd4;
  localparam logic [4:0] STAGE3_AMT = 5'd2;
  localparam logic [4:0] STAGE4_AMT = 5'd1;

  localparam logic [2:0] LAST_STAGE = 3'd4;

  function automatic logic [4:0] stage_amt(input logic [2:0] idx);
    case (idx)
      3'd0:    return STAGE0_AMT;
      3'd1:    return STAGE1_AMT;
      3'd2:    return STAGE2_AMT;
      3'd3:    return STAGE3_AMT;
      default: return STAGE4_AMT;
    endcase
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: combinational single-stage shifter; shifts din by amt according
// to op.  SLL/SRL fill with zeros, SRA replicates din's MSB.  ROR is a true
// rotate only when SHIFT_ROTATE_EN is defined; otherwise din passes through.
//   op   : operation (opcode_e)
//   amt  : shift amount for this stage
//   din  : working value in
//   dout : shifted value out
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  opcode_e        op,
  input  logic [4:0]     amt,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout
);

`ifdef SHIFT_ROTATE_EN
  // Rotate via a doubled word: bits shifted out of the bottom reappear on top.
  logic [2*W-1:0] dbl;
  assign dbl = {din, din} >> amt;
`endif

  always_comb begin
    dout = din;
    case (op)
      OP_SLL: dout = din << amt;
      OP_SRL: dout = din >> amt;
      OP_SRA: dout = $signed(din) >>> amt;
`ifdef SHIFT_ROTATE_EN
      OP_ROR: dout = dbl[W-1:0];
`else
      OP_ROR: dout = din;
`endif
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: multi-cycle 32-bit barrel-shift controller.  One request at a
// time; a nonzero shift walks five fixed stages (16, 8, 4, 2, 1), each applied
// only when the matching shamt bit is set.  Optional macro SHIFT_ROTATE_EN
// makes opcode 11 a rotate-right; without it opcode 11 returns data_in.
//   clock, reset       : rising-edge clock, async active-high reset
//   in_valid/in_ready  : request handshake (ready only in IDLE)
//   opcode/data_in/shamt : request payload, latched on accept
//   out_valid/out_ready: result handshake (valid only in DONE)
//   data_out           : result, stable while out_valid
//   busy               : high whenever not IDLE
module shift_ctrl
  import shift_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  opcode,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        busy
);

  state_e      state_q, state_n;
  logic [2:0]  idx_q, idx_n;
  opcode_e     op_q, op_n;
  logic [31:0] work_q, work_n;
  logic [4:0]  shamt_q, shamt_n;

  logic [31:0] stage_dout;
  logic [4:0]  amt;
  logic        stage_en;
  logic        op_impl;

  assign amt = stage_amt(idx_q);
  // Stage index 0 handles 16 (shamt bit 4) down to index 4 handling 1 (bit 0).
  assign stage_en = shamt_q[LAST_STAGE - idx_q];

`ifdef SHIFT_ROTATE_EN
  assign op_impl = 1'b1;
`else
  assign op_impl = (opcode != OP_ROR);
`endif

  shift_stage #(.W(32)) u_stage (
    .op   (op_q),
    .amt  (amt),
    .din  (work_q),
    .dout (stage_dout)
  );

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    op_n    = op_q;
    work_n  = work_q;
    shamt_n = shamt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_n    = opcode_e'(opcode);
          work_n  = data_in;
          shamt_n = shamt;
          idx_n   = '0;
          state_n = (shamt != '0 && op_impl) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (stage_en) work_n = stage_dout;
        if (idx_q == LAST_STAGE) begin
          idx_n   = '0;
          state_n = ST_DONE;
        end else begin
          idx_n = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= OP_SLL;
      work_q  <= '0;
      shamt_q <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      op_q    <= op_n;
      work_q  <= work_n;
      shamt_q <= shamt_n;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign data_out  = work_q;

endmodule

// File: tb/tb_shift_ctrl.sv
module tb_shift_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  opcode;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  shift_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .data_in   (data_in),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      2'b00: r = d << sh;
      2'b01: r = d >> sh;
      2'b10: r = 32'($signed(d) >>> sh);
      default: begin
`ifdef SHIFT_ROTATE_EN
        if (sh == 5'd0) r = d;
        else r = (d >> sh) | (d << (6'd32 - {1'b0, sh}));
`else
        r = d;
`endif
      end
    endcase
    return r;
  endfunction

  // Edges after the accept edge until out_valid is seen.
  function automatic int model_lat(input logic [1:0] op, input logic [4:0] sh);
    if (sh == 5'd0) return 0;
`ifndef SHIFT_ROTATE_EN
    if (op == 2'b11) return 0;
`endif
    return 5;
  endfunction

  // Present a request for one edge, record the expected result, then leave
  // junk on the request inputs with in_valid high while the DUT is busy.
  task automatic drive_req(input string name, input logic [1:0] op,
                           input logic [31:0] d, input logic [4:0] sh);
    exp_t e;
    e.data = model(op, d, sh);
    e.lat  = model_lat(op, sh);
    e.name = name;
    sb.push_back(e);
    opcode   = op;
    data_in  = d;
    shamt    = sh;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    opcode  = 2'($urandom);
    data_in = $urandom;
    shamt   = 5'($urandom);
  endtask

  task automatic wait_valid(output int k, output bit timed_out);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clock);
      #1;
      k++;
    end
    timed_out = !out_valid;
  endtask

  task automatic release_out();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    data_in   = '0;
    shamt     = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset data_out got=%h exp=00000000", data_out); end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_sra();
    exp_t e; int k; bit to;
    drive_req("sra16", 2'b10, 32'h80000000, 5'd16);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL sra16 busy/in_ready got=%b/%b exp=1/0", busy, in_ready); end
    wait_valid(k, to);
    e = sb.pop_front();
    checks++; if (to || k !== e.lat) begin failures++; $display("FAIL %s latency got=%0d timeout=%0d exp=%0d", e.name, k, to, e.lat); end
    checks++; if (data_out !== 32'hFFFF8000 || data_out !== e.data) begin failures++; $display("FAIL %s data got=%h exp=%h", e.name, data_out, e.data); end
    release_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL sra16 release in_ready/out_valid got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_srl_sll();
    logic [1:0]  ops [2] = '{2'b01, 2'b00};
    logic [31:0] ds  [2] = '{32'h80000000, 32'h00000001};
    logic [31:0] xs  [2] = '{32'h00000001, 32'h80000000};
    exp_t e; int k; bit to;
    for (int i = 0; i < 2; i++) begin
      drive_req((i == 0) ? "srl31" : "sll31", ops[i], ds[i], 5'd31);
      wait_valid(k, to);
      e = sb.pop_front();
      checks++; if (to || k !== e.lat) begin failures++; $display("FAIL %s latency got=%0d timeout=%0d exp=%0d", e.name, k, to, e.lat); end
      checks++; if (data_out !== xs[i] || data_out !== e.data) begin failures++; $display("FAIL %s data got=%h exp=%h", e.name, data_out, xs[i]); end
      release_out();
    end
  endtask

  task automatic test_zero();
    exp_t e; int k; bit to;
    drive_req("sll0", 2'b00, 32'h12345678, 5'd0);
    wait_valid(k, to);
    e = sb.pop_front();
    checks++; if (to || k !== 0) begin failures++; $display("FAIL %s latency got=%0d timeout=%0d exp=0", e.name, k, to); end
    checks++; if (data_out !== 32'h12345678) begin failures++; $display("FAIL %s data got=%h exp=12345678", e.name, data_out); end
    release_out();
  endtask

  task automatic test_backpressure();
    exp_t e; int k; bit to;
    drive_req("bp", 2'b01, 32'hF0F0F0F0, 5'd4);
    wait_valid(k, to);
    e = sb.pop_front();
    checks++; if (to || data_out !== e.data) begin failures++; $display("FAIL bp data got=%h exp=%h", data_out, e.data); end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (data_out !== e.data || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp hold%0d data=%h in_ready=%b busy=%b out_valid=%b exp data=%h 0 1 1",
                 i, data_out, in_ready, busy, out_valid, e.data);
      end
    end
    release_out();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp release in_ready=%b busy=%b out_valid=%b exp 1 0 0", in_ready, busy, out_valid); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int k; bit to;
    drive_req("abort", 2'b00, 32'hA5A5A5A5, 5'd13);
    void'(sb.pop_back());
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || data_out !== 32'h0) begin failures++; $display("FAIL midreset out_valid=%b data_out=%h exp 0 00000000", out_valid, data_out); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midreset in_ready=%b busy=%b exp 1 0", in_ready, busy); end
    #1;
    reset = 1'b0;
    drive_req("after_reset", 2'b01, 32'hDEADBEEF, 5'd5);
    wait_valid(k, to);
    e = sb.pop_front();
    checks++; if (to || k !== e.lat) begin failures++; $display("FAIL %s latency got=%0d timeout=%0d exp=%0d", e.name, k, to, e.lat); end
    checks++; if (data_out !== 32'h06F56DF7) begin failures++; $display("FAIL %s data got=%h exp=06f56df7", e.name, data_out); end
    release_out();
  endtask

  task automatic test_ror();
    exp_t e; int k; bit to;
    drive_req("ror4", 2'b11, 32'h00000001, 5'd4);
    wait_valid(k, to);
    e = sb.pop_front();
`ifdef SHIFT_ROTATE_EN
    checks++; if (to || k !== 5) begin failures++; $display("FAIL ror4 latency got=%0d timeout=%0d exp=5", k, to); end
    checks++; if (data_out !== 32'h10000000) begin failures++; $display("FAIL ror4 data got=%h exp=10000000", data_out); end
`else
    checks++; if (to || k !== 0) begin failures++; $display("FAIL ror4 latency got=%0d timeout=%0d exp=0", k, to); end
    checks++; if (data_out !== 32'h00000001) begin failures++; $display("FAIL ror4 data got=%h exp=00000001", data_out); end
`endif
    release_out();
  endtask

  // out_ready held high throughout: it must not disturb SHIFT timing, and
  // each result is consumed on its first DONE edge.
  task automatic test_back_to_back();
    exp_t e; int k; bit to;
    logic [1:0] op; logic [31:0] d; logic [4:0] sh;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      sh = (i % 4 == 3) ? 5'd0 : 5'($urandom_range(1, 31));
      drive_req($sformatf("b2b%0d", i), op, d, sh);
      wait_valid(k, to);
      e = sb.pop_front();
      checks++; if (to || k !== e.lat) begin failures++; $display("FAIL %s latency got=%0d timeout=%0d exp=%0d", e.name, k, to, e.lat); end
      checks++; if (data_out !== e.data) begin failures++; $display("FAIL %s data op=%0d d=%h sh=%0d got=%h exp=%h", e.name, op, d, sh, data_out, e.data); end
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL %s return in_ready=%b out_valid=%b exp 1 0", e.name, in_ready, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sra();
    test_srl_sll();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_ror();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
